// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
//   Two-entry elastic pipeline register (main entry + skid entry). Gives a
//   one-cycle latency, full throughput, and a registered in_ready_o so the
//   upstream ready path is cut at this stage.
//
//   Optional feature: define PIPE_PERF_CNT_EN to add the stall/bubble
//   performance counters and their ports.
//
// Ports
//   CLK           clock, rising edge
//   RESET         synchronous, active-high reset
//   flush_i       synchronous drop of all held entries
//   in_valid_i    upstream entry valid
//   in_ready_o    block can accept an entry (registered)
//   in_ctrl_i     upstream control bits
//   in_data_i     upstream payload
//   out_valid_o   downstream entry valid
//   out_ready_i   downstream accepts
//   out_ctrl_o    held control bits (all-zero while not valid)
//   out_data_o    held payload (DATA_FLUSH while not valid)
//   stall_cnt_o   cycles with out_valid_o=1 and out_ready_i=0 (PIPE_PERF_CNT_EN)
//   bubble_cnt_o  non-reset cycles with out_valid_o=0 (PIPE_PERF_CNT_EN)
module pipe_skid_reg #(
    parameter int unsigned        DATA_W     = 32,
    parameter int unsigned        CTRL_W     = 8,
    parameter logic [DATA_W-1:0]  DATA_FLUSH = DATA_W'(32'hFFFF_FFFF),
    parameter int unsigned        CNT_W      = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
`endif
);

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("pipe_skid_reg: CNT_W must be at least 1");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                in_fire, out_fire;

    // The main entry is reloaded with the bubble pattern whenever the block
    // goes empty, so the data outputs come straight from registers.
    assign out_valid_o = (state_q != EMPTY);
    assign in_ready_o  = in_ready_q;
    assign out_ctrl_o  = main_ctrl_q;
    assign out_data_o  = main_data_q;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush_i) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = DATA_FLUSH;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl_i;
                        main_data_d = in_data_i;
                    end else if (in_fire) begin
                        skid_ctrl_d = in_ctrl_i;
                        skid_data_d = in_data_i;
                        state_d     = SKID;
                    end else if (out_fire) begin
                        main_ctrl_d = '0;
                        main_data_d = DATA_FLUSH;
                        state_d     = EMPTY;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        state_d     = FULL;
                    end
                end
                default: begin
                    main_ctrl_d = '0;
                    main_data_d = DATA_FLUSH;
                    state_d     = EMPTY;
                end
            endcase
        end

        // Ready is a function of the next state so it can be registered.
        in_ready_d = (state_d != SKID);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_ctrl_q <= '0;
            main_data_q <= DATA_FLUSH;
            skid_ctrl_q <= '0;
            skid_data_q <= DATA_FLUSH;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; flush does not clear them, only RESET does.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (out_valid_o && !out_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (!out_valid_o && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
